// File: rtl/dm_spi_apb_sequencer.sv
// -----------------------------------------------------------------------------
// dm_spi_apb_sequencer
//   APB master that feeds 16-bit DAC frames to a CoreSPI instance (16-bit APB,
//   7-bit PADDR). After reset it writes CONTROL once. For each accepted frame it
//   rewrites SSEL only when the target slave changes. It polls STATUS until the
//   TX FIFO has space, then writes TXDATA. A PSLVERR or a poll timeout sets the
//   sticky err flag.
//
//   Optional feature macro: DMSEQ_READBACK_EN
//     When defined, each TXDATA write is followed by STATUS polling until the
//     RX FIFO is non-empty, then an RXDATA read that pulses rx_valid/rx_data.
//     When undefined, rx_valid and rx_data are tied to 0.
//
// Ports
//   PCLK, PRESETN            clock, asynchronous active-low reset
//   s_valid/s_ready          frame stream handshake
//   s_data, s_ssel           DAC frame and target slave index
//   err_clr                  one-cycle pulse that clears err
//   busy, err                status (busy = not idle, err = sticky error)
//   rx_valid, rx_data        readback word (readback build only)
//   m_p*                     APB master bus
// -----------------------------------------------------------------------------
module dm_spi_apb_sequencer #(
  parameter logic [6:0]  ADDR_CTRL        = 7'h00,
  parameter logic [6:0]  ADDR_TXDATA      = 7'h0C,
  parameter logic [6:0]  ADDR_STATUS      = 7'h20,
  parameter logic [6:0]  ADDR_SSEL        = 7'h24,
  parameter logic [6:0]  ADDR_RXDATA      = 7'h08,
  parameter logic [15:0] CTRL_INIT        = 16'h0003,
  parameter int          STAT_TXFULL_BIT  = 8,
  parameter int          STAT_RXEMPTY_BIT = 6,
  parameter int          POLL_MAX         = 255
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic [2:0]  s_ssel,
  input  logic        err_clr,
  output logic        busy,
  output logic        err,
  output logic        rx_valid,
  output logic [15:0] rx_data,
  output logic [6:0]  m_paddr,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [15:0] m_pwdata,
  input  logic [15:0] m_prdata,
  input  logic        m_pready,
  input  logic        m_pslverr
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SSEL,
    ST_POLL,
    ST_WRTX
`ifdef DMSEQ_READBACK_EN
    , ST_RXPOLL,
    ST_RDRX
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [15:0] data_q, data_d;
  logic [2:0]  tgt_q, tgt_d;
  logic [2:0]  cur_ssel_q, cur_ssel_d;
  logic        ssel_valid_q, ssel_valid_d;
  logic        err_q, err_d, err_set;
  logic        s_ready_q, busy_q;
  logic        psel_q, penable_q, pwrite_q;
  logic [6:0]  paddr_q;
  logic [15:0] pwdata_q;
  logic        launch;     // load a new SETUP phase for state_d at this edge
  logic        xfer_done;  // ACCESS phase completing at this edge

  // Bus attributes of the single transfer each state performs.
  function automatic logic [6:0] addr_of(input state_e st);
    case (st)
      ST_INIT:   return ADDR_CTRL;
      ST_SSEL:   return ADDR_SSEL;
      ST_POLL:   return ADDR_STATUS;
      ST_WRTX:   return ADDR_TXDATA;
`ifdef DMSEQ_READBACK_EN
      ST_RXPOLL: return ADDR_STATUS;
      ST_RDRX:   return ADDR_RXDATA;
`endif
      default:   return 7'h00;
    endcase
  endfunction

  function automatic logic write_of(input state_e st);
    return (st == ST_INIT) || (st == ST_SSEL) || (st == ST_WRTX);
  endfunction

  function automatic logic [15:0] wdata_of(input state_e st, input logic [15:0] d,
                                           input logic [2:0] s);
    case (st)
      ST_INIT: return CTRL_INIT;
      ST_SSEL: return 16'h0001 << s;
      ST_WRTX: return d;
      default: return 16'h0000;
    endcase
  endfunction

`ifdef DMSEQ_READBACK_EN
  logic        rx_fire;
  logic        rx_valid_q;
  logic [15:0] rx_data_q;
`endif

  assign xfer_done = psel_q & penable_q & m_pready;
  assign cnt_inc   = cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    tgt_d        = tgt_q;
    cur_ssel_d   = cur_ssel_q;
    ssel_valid_d = ssel_valid_q;
    launch       = 1'b0;
    err_set      = 1'b0;
`ifdef DMSEQ_READBACK_EN
    rx_fire      = 1'b0;
`endif
    case (state_q)
      ST_INIT: begin
        // Bus is idle straight out of reset, so the CONTROL write starts here.
        if (!psel_q) launch = 1'b1;
        else if (xfer_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (s_valid && s_ready_q) begin
          data_d  = s_data;
          tgt_d   = s_ssel;
          launch  = 1'b1;
          state_d = (!ssel_valid_q || (s_ssel != cur_ssel_q)) ? ST_SSEL : ST_POLL;
        end
      end
      ST_SSEL: begin
        if (xfer_done) begin
          cur_ssel_d   = tgt_q;
          ssel_valid_d = 1'b1;
          state_d      = ST_POLL;
          launch       = 1'b1;
        end
      end
      ST_POLL: begin
        if (xfer_done) begin
          if (!m_prdata[STAT_TXFULL_BIT]) begin
            cnt_d   = 8'd0;
            state_d = ST_WRTX;
            launch  = 1'b1;
          end else if (cnt_inc == 8'(POLL_MAX)) begin
            // Timeout: the frame is dropped.
            cnt_d   = 8'd0;
            err_set = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d  = cnt_inc;
            launch = 1'b1;
          end
        end
      end
      ST_WRTX: begin
        if (xfer_done) begin
`ifdef DMSEQ_READBACK_EN
          state_d = ST_RXPOLL;
          launch  = 1'b1;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef DMSEQ_READBACK_EN
      ST_RXPOLL: begin
        if (xfer_done) begin
          if (!m_prdata[STAT_RXEMPTY_BIT]) begin
            cnt_d   = 8'd0;
            state_d = ST_RDRX;
            launch  = 1'b1;
          end else if (cnt_inc == 8'(POLL_MAX)) begin
            cnt_d   = 8'd0;
            err_set = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d  = cnt_inc;
            launch = 1'b1;
          end
        end
      end
      ST_RDRX: begin
        if (xfer_done) begin
          rx_fire = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (xfer_done && m_pslverr) err_set = 1'b1;
    // A new error wins over a simultaneous clear.
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q      <= ST_INIT;
      cnt_q        <= 8'd0;
      data_q       <= 16'h0000;
      tgt_q        <= 3'd0;
      cur_ssel_q   <= 3'd0;
      ssel_valid_q <= 1'b0;
      err_q        <= 1'b0;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= 7'h00;
      pwdata_q     <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      tgt_q        <= tgt_d;
      cur_ssel_q   <= cur_ssel_d;
      ssel_valid_q <= ssel_valid_d;
      err_q        <= err_d;
      s_ready_q    <= (state_d == ST_IDLE);
      busy_q       <= (state_d != ST_IDLE);
      if (launch) begin
        // SETUP may directly follow a completion.
        psel_q    <= 1'b1;
        penable_q <= 1'b0;
        paddr_q   <= addr_of(state_d);
        pwrite_q  <= write_of(state_d);
        pwdata_q  <= wdata_of(state_d, data_d, tgt_d);
      end else if (psel_q && !penable_q) begin
        penable_q <= 1'b1;
      end else if (xfer_done) begin
        psel_q    <= 1'b0;
        penable_q <= 1'b0;
        paddr_q   <= 7'h00;
        pwrite_q  <= 1'b0;
        pwdata_q  <= 16'h0000;
      end
    end
  end

`ifdef DMSEQ_READBACK_EN
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= 16'h0000;
    end else begin
      rx_valid_q <= rx_fire;
      if (rx_fire) rx_data_q <= m_prdata;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
`else
  assign rx_valid = 1'b0;
  assign rx_data  = 16'h0000;

  logic unused_ok;
  assign unused_ok = ^{m_prdata, ADDR_RXDATA, (STAT_RXEMPTY_BIT == 0)};
`endif

  assign s_ready   = s_ready_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign m_paddr   = paddr_q;
  assign m_psel    = psel_q;
  assign m_penable = penable_q;
  assign m_pwrite  = pwrite_q;
  assign m_pwdata  = pwdata_q;

endmodule

// File: tb/tb_dm_spi_apb_sequencer.sv
`timescale 1ns/1ps
module tb_dm_spi_apb_sequencer;

  localparam logic [6:0] A_CTRL = 7'h00;
  localparam logic [6:0] A_TX   = 7'h0C;
  localparam logic [6:0] A_STAT = 7'h20;
  localparam logic [6:0] A_SSEL = 7'h24;
  localparam logic [6:0] A_RX   = 7'h08;
`ifdef DMSEQ_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = 16'h0000;
  logic [2:0]  s_ssel = 3'd0;
  logic        err_clr = 1'b0;
  logic        busy, err, rx_valid;
  logic [15:0] rx_data;
  logic [6:0]  m_paddr;
  logic        m_psel, m_penable, m_pwrite;
  logic [15:0] m_pwdata;
  logic [15:0] m_prdata = 16'h0000;
  logic        m_pready = 1'b0;
  logic        m_pslverr = 1'b0;

  always #5 PCLK = ~PCLK;

  dm_spi_apb_sequencer #(.POLL_MAX(4)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ssel(s_ssel),
    .err_clr(err_clr), .busy(busy), .err(err),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  int nvec = 0;
  int nfail = 0;

  // Slave model knobs (written only by the test tasks)
  int tx_waits = 0;
  int full_base = 0;
  int full_n = 0;
  bit slverr_ssel = 1'b0;

  // Monitor state (written only by the monitor)
  int          cyc = 0;
  int          n_w = 0;
  int          n_stat = 0;
  int          rx_cnt = 0;
  int          rx_bad = 0;
  int          hold_err = 0;
  logic        rx_prev = 1'b0;
  logic [22:0] w_ad [64];
  int          w_cyc [64];
  logic [23:0] su = '0;
  int          wcnt = 0;

  // APB slave: STATUS reports TX full for full_n reads after full_base.
  always @(negedge PCLK) begin
    if (m_psel && m_penable) begin
      m_pready  <= (wcnt >= ((m_paddr == A_TX) ? tx_waits : 0));
      m_pslverr <= (wcnt >= ((m_paddr == A_TX) ? tx_waits : 0)) && slverr_ssel && (m_paddr == A_SSEL);
      m_prdata  <= (m_paddr == A_STAT) ? (((n_stat - full_base) < full_n) ? 16'h0100 : 16'h0000)
                 : (m_paddr == A_RX) ? 16'h5A5A : 16'hDEAD;
      wcnt      <= wcnt + 1;
    end else begin
      m_pready  <= 1'b0;
      m_pslverr <= 1'b0;
      m_prdata  <= 16'h0000;
      wcnt      <= 0;
    end
  end

  // Bus monitor
  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (m_psel && !m_penable) su <= {m_paddr, m_pwrite, m_pwdata};
    if (m_psel && m_penable && ({m_paddr, m_pwrite, m_pwdata} !== su)) hold_err <= hold_err + 1;
    if (m_psel && m_penable && m_pready) begin
      if (m_pwrite) begin
        if (n_w < 64) begin
          w_ad[n_w]  <= {m_paddr, m_pwdata};
          w_cyc[n_w] <= cyc;
        end
        n_w <= n_w + 1;
      end else if (m_paddr == A_STAT) begin
        n_stat <= n_stat + 1;
      end
    end
    if (rx_valid) begin
      rx_cnt <= rx_cnt + 1;
      if (rx_data !== 16'h5A5A || rx_prev) rx_bad <= rx_bad + 1;
    end
    rx_prev <= rx_valid;
  end

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge PCLK);
    while (!(s_ready && !busy) && k < 300) begin
      @(negedge PCLK);
      k++;
    end
    if (!(s_ready && !busy)) begin
      nvec++; nfail++;
      $display("FAIL %s idle_timeout: s_ready=%0b busy=%0b after %0d cycles, required 1/0", name, s_ready, busy, k);
    end
  endtask

  task automatic send_frame(input logic [15:0] d, input logic [2:0] s, output int hs);
    int k;
    k = 0;
    hs = -1;
    @(negedge PCLK);
    while (!s_ready && k < 300) begin
      @(negedge PCLK);
      k++;
    end
    if (!s_ready) begin
      nvec++; nfail++;
      $display("FAIL send_ready: s_ready=0 after %0d cycles, required 1", k);
    end else begin
      s_valid = 1'b1; s_data = d; s_ssel = s;
      @(posedge PCLK);
      hs = cyc;
      #1 s_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESETN = 1'b0;
    @(negedge PCLK);
    PRESETN = 1'b1;
    wait_idle("reset");
  endtask

  task automatic test_reset();
    int base;
    PRESETN = 1'b0;
    repeat (2) @(negedge PCLK);
    nvec++;
    if ({m_psel, m_penable, m_pwrite, s_ready, busy, err, rx_valid} !== 7'b0) begin
      nfail++;
      $display("FAIL reset_ctl: psel/pen/pwr/rdy/busy/err/rxv=%b, required 0000000",
               {m_psel, m_penable, m_pwrite, s_ready, busy, err, rx_valid});
    end
    nvec++;
    if ({m_paddr, m_pwdata, rx_data} !== 39'h0) begin
      nfail++;
      $display("FAIL reset_bus: paddr=%h pwdata=%h rx_data=%h, required 0", m_paddr, m_pwdata, rx_data);
    end
    base = n_w;
    PRESETN = 1'b1;
    wait_idle("init");
    nvec++;
    if (n_w - base !== 1) begin
      nfail++; $display("FAIL init_count: %0d writes, required 1", n_w - base);
    end
    nvec++;
    if (w_ad[base] !== {A_CTRL, 16'h0003}) begin
      nfail++; $display("FAIL init_write: addr/data=%h, required %h", w_ad[base], {A_CTRL, 16'h0003});
    end
    nvec++;
    if ({s_ready, busy} !== 2'b10) begin
      nfail++; $display("FAIL init_idle: s_ready/busy=%b, required 10", {s_ready, busy});
    end
  endtask

  task automatic test_same_ssel();
    int base, st0, rx0, h1, h2;
    logic [22:0] exp [3];
    exp[0] = {A_SSEL, 16'h0004}; exp[1] = {A_TX, 16'h1234}; exp[2] = {A_TX, 16'hABCD};
    base = n_w; st0 = n_stat; rx0 = rx_cnt;
    send_frame(16'h1234, 3'd2, h1); wait_idle("f1234");
    send_frame(16'hABCD, 3'd2, h2); wait_idle("fABCD");
    nvec++;
    if (n_w - base !== 3) begin
      nfail++; $display("FAIL same_count: %0d writes, required 3", n_w - base);
    end
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (w_ad[base + i] !== exp[i]) begin
        nfail++; $display("FAIL same_write%0d: %h, required %h", i, w_ad[base + i], exp[i]);
      end
    end
    nvec++;
    if (n_stat - st0 !== 2 + 2 * RB) begin
      nfail++; $display("FAIL same_stat: %0d STATUS reads, required %0d", n_stat - st0, 2 + 2 * RB);
    end
    nvec++;
    if (w_cyc[base + 2] - h2 !== 4) begin
      nfail++; $display("FAIL same_latency: %0d cycles, required 4", w_cyc[base + 2] - h2);
    end
    nvec++;
    if ((rx_cnt - rx0 !== 2 * RB) || (rx_bad !== 0)) begin
      nfail++; $display("FAIL readback: %0d rx pulses (%0d bad), required %0d (0 bad)",
                        rx_cnt - rx0, rx_bad, 2 * RB);
    end
  endtask

  task automatic test_ssel_change();
    int base, h0, h1, h2;
    logic [22:0] exp [5];
    exp[0] = {A_SSEL, 16'h0004}; exp[1] = {A_TX, 16'h1111};
    exp[2] = {A_SSEL, 16'h0020}; exp[3] = {A_TX, 16'h2222}; exp[4] = {A_TX, 16'h3333};
    do_reset();
    base = n_w;
    send_frame(16'h1111, 3'd2, h0); wait_idle("s2");
    send_frame(16'h2222, 3'd5, h1); wait_idle("s5a");
    send_frame(16'h3333, 3'd5, h2); wait_idle("s5b");
    nvec++;
    if (n_w - base !== 5) begin
      nfail++; $display("FAIL sseq_count: %0d writes, required 5", n_w - base);
    end
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (w_ad[base + i] !== exp[i]) begin
        nfail++; $display("FAIL sseq_write%0d: %h, required %h", i, w_ad[base + i], exp[i]);
      end
    end
    nvec++;
    if (w_cyc[base + 3] - h1 !== 6) begin
      nfail++; $display("FAIL sseq_latency: %0d cycles, required 6", w_cyc[base + 3] - h1);
    end
  endtask

  task automatic test_wait_poll();
    int base, st0, h;
    base = n_w; st0 = n_stat;
    full_base = n_stat; full_n = 3; tx_waits = 2;
    send_frame(16'hBEEF, 3'd5, h); wait_idle("wpoll");
    tx_waits = 0; full_n = 0;
    nvec++;
    if (n_stat - st0 !== 4 + RB) begin
      nfail++; $display("FAIL wpoll_stat: %0d STATUS reads, required %0d", n_stat - st0, 4 + RB);
    end
    nvec++;
    if ((n_w - base !== 1) || (w_ad[base] !== {A_TX, 16'hBEEF})) begin
      nfail++; $display("FAIL wpoll_write: %0d writes first=%h, required 1 of %h",
                        n_w - base, w_ad[base], {A_TX, 16'hBEEF});
    end
    nvec++;
    if (w_cyc[base] - h !== 12) begin
      nfail++; $display("FAIL wpoll_latency: %0d cycles, required 12", w_cyc[base] - h);
    end
    nvec++;
    if (hold_err !== 0) begin
      nfail++; $display("FAIL bus_hold: %0d unstable ACCESS cycles, required 0", hold_err);
    end
    nvec++;
    if (err !== 1'b0) begin
      nfail++; $display("FAIL wpoll_err: err=%b, required 0", err);
    end
  endtask

  task automatic test_timeout();
    int base, st0, h;
    base = n_w; st0 = n_stat;
    full_base = n_stat; full_n = 1000;
    send_frame(16'h7777, 3'd5, h); wait_idle("tmo");
    full_n = 0;
    nvec++;
    if (n_stat - st0 !== 4) begin
      nfail++; $display("FAIL tmo_stat: %0d STATUS reads, required 4", n_stat - st0);
    end
    nvec++;
    if (n_w - base !== 0) begin
      nfail++; $display("FAIL tmo_write: %0d writes, required 0", n_w - base);
    end
    nvec++;
    if (err !== 1'b1) begin
      nfail++; $display("FAIL tmo_err: err=%b, required 1", err);
    end
    @(negedge PCLK) err_clr = 1'b1;
    @(negedge PCLK) err_clr = 1'b0;
    nvec++;
    if (err !== 1'b0) begin
      nfail++; $display("FAIL tmo_clr: err=%b, required 0", err);
    end
  endtask

  task automatic test_slverr();
    int base, h;
    base = n_w;
    slverr_ssel = 1'b1;
    send_frame(16'h4242, 3'd7, h); wait_idle("slverr");
    slverr_ssel = 1'b0;
    nvec++;
    if ((n_w - base !== 2) || (w_ad[base] !== {A_SSEL, 16'h0080}) || (w_ad[base + 1] !== {A_TX, 16'h4242})) begin
      nfail++; $display("FAIL slverr_seq: %0d writes %h %h, required 2: %h %h", n_w - base,
                        w_ad[base], w_ad[base + 1], {A_SSEL, 16'h0080}, {A_TX, 16'h4242});
    end
    nvec++;
    if (err !== 1'b1) begin
      nfail++; $display("FAIL slverr_err: err=%b, required 1", err);
    end
    @(negedge PCLK) err_clr = 1'b1;
    @(negedge PCLK) err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base, h, k;
    tx_waits = 6;
    send_frame(16'h9999, 3'd7, h);
    k = 0;
    @(negedge PCLK);
    while (!(m_psel && m_penable && m_paddr == A_TX) && k < 50) begin
      @(negedge PCLK);
      k++;
    end
    nvec++;
    if (!(m_psel && m_penable && m_paddr == A_TX)) begin
      nfail++; $display("FAIL rstmid_access: TXDATA ACCESS not seen in %0d cycles", k);
    end
    #2 PRESETN = 1'b0;
    #1;
    nvec++;
    if ({m_psel, m_penable, busy} !== 3'b000) begin
      nfail++; $display("FAIL rstmid_abort: psel/pen/busy=%b, required 000", {m_psel, m_penable, busy});
    end
    tx_waits = 0;
    base = n_w;
    @(negedge PCLK) PRESETN = 1'b1;
    wait_idle("rstmid");
    nvec++;
    if ((n_w - base !== 1) || (w_ad[base] !== {A_CTRL, 16'h0003})) begin
      nfail++; $display("FAIL rstmid_init: %0d writes first=%h, required 1 of %h",
                        n_w - base, w_ad[base], {A_CTRL, 16'h0003});
    end
  endtask

  initial begin
    test_reset();
    test_same_ssel();
    test_ssel_change();
    test_wait_poll();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
